// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through / no-write-allocate data cache controller for the
// MEM stage. One 32-bit word per line; any miss or store freezes the pipeline.
module dcache_ctrl #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wenable,
  input  logic        renable,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        hit,
  output logic        mem_wenable,
  output logic        mem_renable,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_MEM  = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state, next_state;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_arr  [LINES];
  logic [31:0]      data_arr [LINES];

  logic done_rd;
  logic mem_renable_q;
  logic mem_wenable_q;

  logic [INDEX_BITS-1:0] index;
  logic [TAG_W-1:0]      tag;
  logic [31:0]           word_addr;
  logic [31:0]           line_data;
  logic                  lookup_hit;
  logic                  fill;
  logic                  wr_hit_update;

  assign index         = addr[INDEX_BITS+1:2];
  assign tag           = addr[31:INDEX_BITS+2];
  assign word_addr     = addr & 32'hFFFF_FFFC;
  assign line_data     = data_arr[index];
  assign lookup_hit    = (renable | wenable) & valid[index] & (tag_arr[index] == tag);
  assign fill          = (state == RD_MISS) & mem_ready;
  assign wr_hit_update = (state == IDLE) & wenable & lookup_hit;

  assign mem_renable = mem_renable_q;
  assign mem_wenable = mem_wenable_q;

  // Control state: reset clears valid bits, which also aborts any pending fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      valid         <= '0;
      done_rd       <= 1'b0;
      mem_renable_q <= 1'b0;
      mem_wenable_q <= 1'b0;
    end else begin
      state         <= next_state;
      done_rd       <= fill;
      mem_renable_q <= (next_state == RD_MISS);
      mem_wenable_q <= (next_state == WR_MEM);
      if (fill) begin
        valid[index] <= 1'b1;
      end
    end
  end

  // Tag/data storage; contents are meaningless unless the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_arr[index]  <= tag;
      data_arr[index] <= mem_rdata;
    end else if (wr_hit_update) begin
      data_arr[index] <= wdata;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (wenable) begin
          next_state = WR_MEM;
        end else if (renable && !lookup_hit) begin
          next_state = RD_MISS;
        end
      end
      RD_MISS: if (mem_ready) next_state = DONE;
      WR_MEM:  if (mem_ready) next_state = DONE;
      DONE:    next_state = IDLE;
    endcase
  end

  // A store takes priority over a load when both enables are raised together.
  always_comb begin
    stall     = 1'b0;
    hit       = 1'b0;
    rdata     = 32'h0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          hit   = lookup_hit;
          stall = wenable | (renable & ~lookup_hit);
          if (renable && !wenable && lookup_hit) begin
            rdata = line_data;
          end
        end
        RD_MISS: begin
          stall    = 1'b1;
          mem_addr = word_addr;
        end
        WR_MEM: begin
          stall     = 1'b1;
          mem_addr  = word_addr;
          mem_wdata = wdata;
        end
        DONE: begin
          hit = done_rd;
          if (done_rd) begin
            rdata = line_data;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized bench for dcache_ctrl: a transaction-level cache/memory model
// predicts hit/miss, stall length, returned data and memory writes.
module tb_dcache_ctrl;
  localparam int IB    = 4;
  localparam int LINES = 1 << IB;
  localparam int TAG_W = 30 - IB;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wenable;
  logic        renable;
  logic [31:0] rdata;
  logic        stall;
  logic        hit;
  logic        mem_wenable;
  logic        mem_renable;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  dcache_ctrl #(.INDEX_BITS(IB)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .wdata      (wdata),
    .wenable    (wenable),
    .renable    (renable),
    .rdata      (rdata),
    .stall      (stall),
    .hit        (hit),
    .mem_wenable(mem_wenable),
    .mem_renable(mem_renable),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Backing memory: sparse written words, everything else is a fixed address hash.
  bit [31:0]   mem_model [bit [31:0]];
  int          mem_lat    = 3;
  bit          mem_manual = 1'b0;
  int          mem_cnt    = 0;
  int          wr_count   = 0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [31:0] last_wr_data = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'hA5C3_96E1;
  endfunction

  always @(negedge clk) begin
    if (!mem_manual) begin
      if (mem_renable || mem_wenable) begin
        mem_cnt++;
        mem_ready = (mem_cnt == mem_lat);
        if (mem_ready && mem_renable) mem_rdata = mem_word(mem_addr);
        if (mem_ready && mem_wenable) begin
          mem_model[mem_addr] = mem_wdata;
          wr_count++;
          last_wr_addr = mem_addr;
          last_wr_data = mem_wdata;
        end
      end else begin
        mem_cnt   = 0;
        mem_ready = 1'b0;
      end
    end
  end

  // Cache reference: what each line should hold after every retired access.
  bit               ref_valid [LINES];
  logic [TAG_W-1:0] ref_tag   [LINES];
  logic [31:0]      ref_data  [LINES];

  task automatic access(input bit we, input bit re, input logic [31:0] a,
                        input logic [31:0] wd, input int lat);
    int               idx;
    logic [TAG_W-1:0] tg;
    logic [31:0]      word;
    logic [31:0]      rd_exp;
    bit               exp_hit;
    bit               stalls;
    bit               done;
    int               cycles;
    int               wr_before;
    idx     = int'(a[IB+1:2]);
    tg      = a[31:IB+2];
    word    = {a[31:2], 2'b00};
    exp_hit = (we || re) && ref_valid[idx] && (ref_tag[idx] == tg);
    stalls  = we || (re && !exp_hit);
    rd_exp  = we ? 32'h0 : (exp_hit ? ref_data[idx] : mem_word(word));

    @(negedge clk);
    mem_lat = lat;
    addr    = a;
    wdata   = wd;
    wenable = we;
    renable = re;
    #1;
    check("hit_idle", hit, exp_hit);
    check("stall_idle", stall, stalls);
    check("rdata_idle", rdata, (re && !we && exp_hit) ? ref_data[idx] : 32'h0);
    check("mem_ren_idle", mem_renable, 0);
    check("mem_wen_idle", mem_wenable, 0);

    if (stalls) begin
      wr_before = wr_count;
      cycles    = 1;
      done      = 1'b0;
      for (int k = 0; k < 200 && !done; k++) begin
        @(negedge clk);
        #1;
        if (!stall) begin
          done = 1'b1;
        end else begin
          cycles++;
          check("mem_ren_busy", mem_renable, !we);
          check("mem_wen_busy", mem_wenable, we);
          check("mem_addr_busy", mem_addr, word);
          check("mem_wdata_busy", mem_wdata, we ? wd : 32'h0);
          check("hit_busy", hit, 0);
          check("rdata_busy", rdata, 0);
        end
      end
      if (!done) check("done_timeout", 0, 1);
      check("stall_cycles", cycles, lat + 1);
      check("hit_done", hit, !we);
      check("rdata_done", rdata, rd_exp);
      check("mem_ren_done", mem_renable, 0);
      check("mem_wen_done", mem_wenable, 0);
      if (we) begin
        check("mem_write_count", wr_count, wr_before + 1);
        check("mem_write_addr", last_wr_addr, word);
        check("mem_write_data", last_wr_data, wd);
        if (exp_hit) ref_data[idx] = wd;
      end else begin
        check("no_mem_write", wr_count, wr_before);
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = tg;
        ref_data[idx]  = rd_exp;
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    addr      = 32'h40;
    wdata     = 32'h0;
    wenable   = 1'b0;
    renable   = 1'b1;
    mem_rdata = 32'h0;
    mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", stall, 0);
    check("rst_hit", hit, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_ren", mem_renable, 0);
    check("rst_mem_wen", mem_wenable, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    @(negedge clk);
    rst     = 1'b0;
    renable = 1'b0;
    #1;
    check("idle_stall", stall, 0);
    check("idle_hit", hit, 0);

    // Cold read then repeated hit
    mem_model[32'h40] = 32'hDEADBEEF;
    access(1'b0, 1'b1, 32'h40, 32'h0, 3);
    access(1'b0, 1'b1, 32'h40, 32'h0, 3);
    check("cold_read_filled", ref_data[0], 32'hDEADBEEF);

    // Store hit, then load sees the new word
    access(1'b1, 1'b0, 32'h40, 32'h12345678, 2);
    access(1'b0, 1'b1, 32'h43, 32'h0, 2);

    // Store miss does not allocate
    access(1'b1, 1'b0, 32'h80, 32'hCAFEF00D, 2);
    access(1'b0, 1'b1, 32'h80, 32'h0, 1);

    // Conflict eviction on index 0
    access(1'b0, 1'b1, 32'h440, 32'h0, 2);
    access(1'b0, 1'b1, 32'h40, 32'h0, 2);

    // Both enables: treated as a store, no fill
    access(1'b1, 1'b1, 32'h100, 32'h0BADCAFE, 1);
    access(1'b0, 1'b1, 32'h100, 32'h0, 1);

    // Reset during a read miss aborts it; a late mem_ready is ignored
    @(negedge clk);
    mem_lat = 1000;
    addr    = 32'h200;
    renable = 1'b1;
    wenable = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("midmiss_ren", mem_renable, 1);
    @(negedge clk);
    rst     = 1'b1;
    renable = 1'b0;
    @(negedge clk);
    #1;
    check("abort_mem_ren", mem_renable, 0);
    check("abort_stall", stall, 0);
    check("abort_mem_addr", mem_addr, 0);
    rst        = 1'b0;
    mem_manual = 1'b1;
    mem_rdata  = 32'hBAADF00D;
    mem_ready  = 1'b1;
    @(negedge clk);
    #1;
    check("late_ready_stall", stall, 0);
    check("late_ready_ren", mem_renable, 0);
    mem_ready  = 1'b0;
    mem_manual = 1'b0;
    mem_cnt    = 0;
    for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
    access(1'b0, 1'b1, 32'h200, 32'h0, 2);

    // Randomized mix over a small tag pool to provoke hits and conflicts
    for (int n = 0; n < 250; n++) begin
      logic [31:0] a;
      int          op;
      a  = ($urandom_range(0, 3) << (IB + 2)) | ($urandom_range(0, LINES - 1) << 2)
           | $urandom_range(0, 3);
      op = $urandom_range(0, 9);
      if (op < 4)       access(1'b0, 1'b1, a, $urandom, $urandom_range(1, 4));
      else if (op < 7)  access(1'b1, 1'b0, a, $urandom, $urandom_range(1, 4));
      else if (op == 7) access(1'b1, 1'b1, a, $urandom, $urandom_range(1, 4));
      else              access(1'b0, 1'b0, a, $urandom, $urandom_range(1, 4));
    end

    @(negedge clk);
    wenable = 1'b0;
    renable = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter INDEX_BITS, default 4, gives the number of lines as 2^INDEX_BITS, with one 32-bit word per line.
REQ-002 Ports are listed below; the block has one clock, and reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- addr  in  32  byte address from the MEM stage ALU result; bits [1:0] ignored
- wdata  in  32  store data from the MEM stage
- wenable  in  1  store request, held by the pipeline while stall=1
- renable  in  1  load request, held by the pipeline while stall=1
- rdata  out  32  load data to MEMWB
- stall  out  1  freeze PC, IFID, IDEX, EXMEM and MEMWB
- hit  out  1  the current request hits a valid line
- mem_wenable  out  1  memory write request, level
- mem_renable  out  1  memory read request, level
- mem_addr  out  32  word-aligned memory address ({addr[31:2],2'b00})
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid when mem_ready=1
- mem_ready  in  1  one-cycle completion pulse for the outstanding memory request

Function
REQ-003 Organisation: direct-mapped; index = addr[INDEX_BITS+1:2]; tag = addr[31:INDEX_BITS+2]; each line holds one valid bit, the tag and a 32-bit data word.
REQ-004 Write policy: write-through, no-write-allocate.
REQ-005 FSM states: IDLE, RD_MISS, WR_MEM, DONE.
REQ-006 hit = (renable|wenable) & valid[index] & (tag match), and is forced to 0 outside IDLE except in DONE after a read, where it is 1.
REQ-007 IDLE with no request: stall=0, both mem enables 0, state stays IDLE.
REQ-008 IDLE with a read hit: rdata = line data combinationally, stall=0, zero added latency, state stays IDLE.
REQ-009 IDLE with a read miss: stall=1 in the same cycle; next state is RD_MISS.
REQ-010 IDLE with wenable=1 (hit or miss): stall=1 in the same cycle; next state is WR_MEM.
REQ-011 A write hit updates the line data at the IDLE->WR_MEM edge.
REQ-012 A write miss leaves the array untouched.
REQ-013 When wenable and renable are both 1, the access is treated as a write and renable is ignored.
REQ-014 RD_MISS: mem_renable=1, mem_addr per REQ-002, stall=1; the state is held until mem_ready=1.
REQ-015 On the mem_ready edge in RD_MISS, the line is filled: data=mem_rdata, tag written, valid=1; next state is DONE.
REQ-016 WR_MEM: mem_wenable=1, mem_wdata=wdata, stall=1; the state is held until mem_ready=1, then next state is DONE.
REQ-017 DONE lasts exactly one cycle: stall=0, both mem enables 0, and rdata = the filled line word for a read; next state is IDLE unconditionally.
REQ-018 In DONE, the held request is considered retired and the array is not re-evaluated or rewritten.
REQ-019 mem_renable and mem_wenable are never 1 in the same cycle.
REQ-020 Both mem enables are registered outputs decoded from state only.
REQ-021 A mem_ready pulse in IDLE or DONE is ignored.
REQ-022 rdata is 32'h0 whenever no read is returning data (IDLE without a read hit, WR_MEM, RD_MISS).
REQ-023 Miss penalty is (memory latency + 1) stalled cycles plus the DONE cycle; hit latency is 0.

Reset
REQ-024 While rst=1 at a clock edge: state=IDLE and all valid bits are cleared; tags and data are don't-care.
REQ-025 While rst=1 and after reset, outputs are stall=0, hit=0, rdata=0, mem_renable=0, mem_wenable=0, mem_addr=0, mem_wdata=0.
REQ-026 Reset asserted during RD_MISS or WR_MEM aborts the access: the enable drops in the first cycle after the reset edge, no line is filled, and a subsequent mem_ready is ignored.

Verification
REQ-027 Cold read: after reset, renable=1, addr=0x40, memory returns 0xDEADBEEF after 3 cycles -> stall=1 for 4 cycles, one DONE cycle with rdata=0xDEADBEEF and stall=0; the same load repeated gives hit=1, stall=0, rdata=0xDEADBEEF.
REQ-028 Store hit: after the REQ-027 fill, wenable=1, addr=0x40, wdata=0x12345678 -> mem_wenable=1 with mem_wdata=0x12345678 until mem_ready; a later load from 0x40 hits and returns 0x12345678.
REQ-029 Store miss: wenable=1, addr=0x80, cold cache -> memory write occurs; a later load from 0x80 misses (no allocate).
REQ-030 Conflict eviction (INDEX_BITS=4): load 0x40 then load 0x440 (same index, different tag) -> second load misses and refills; a reload of 0x40 misses again.
REQ-031 Simultaneous enables: renable=1 and wenable=1 -> only mem_wenable asserts and there is no read fill.
REQ-032 Reset mid-miss: rst pulsed during RD_MISS, then mem_ready arrives -> mem_renable=0 after the reset edge; the following load from the same address still misses.
